// File: rtl/handshake_pkg.sv
// handshake_pkg
// Shared types and constants for the source side of the 4-phase req/ack
// clock-domain-crossing handshake.
//   tx_state_t : transmitter state (IDLE, REQ_HIGH, REQ_LOW)
//   COUNT_W    : width of the completed-transfer counter
package handshake_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ_HIGH = 2'd1,
    REQ_LOW  = 2'd2
  } tx_state_t;

  localparam int COUNT_W = 16;

endpackage

// File: rtl/flipflop_synchronizer.sv
// flipflop_synchronizer
// Plain multi-flop synchronizer for bringing an asynchronous level into the
// clock domain. The chain is deliberately not reset: it keeps sampling while
// the rest of the logic is held in reset, so the synchronized level is already
// correct when reset is released (provided reset lasts at least NUM_OF_STAGES
// clock cycles).
// Parameters:
//   WIDTH         : number of independent single-bit levels
//   NUM_OF_STAGES : flops in the chain (2 or more)
// Ports:
//   clock : destination-domain clock, rising edge
//   d     : asynchronous input level(s)
//   q     : synchronized level(s)
module flipflop_synchronizer #(
  parameter int WIDTH         = 1,
  parameter int NUM_OF_STAGES = 2
) (
  input  logic             clock,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stages [NUM_OF_STAGES];

  // Shift the incoming level down the chain one flop per clock.
  always_ff @(posedge clock) begin
    stages[0] <= d;
    for (int i = 1; i < NUM_OF_STAGES; i++) begin
      stages[i] <= stages[i-1];
    end
  end

  assign q = stages[NUM_OF_STAGES-1];

endmodule

// File: rtl/handshake_tx.sv
// handshake_tx
// Transmitter end of the 4-phase req/ack handshake. A word accepted over
// valid/ready is held on tx_data while req is raised; the receiver's ack is
// synchronized, req is dropped when it arrives, and the block waits for ack
// to return low before accepting the next word.
// Parameters:
//   WIDTH       : data word width
//   SYNC_STAGES : synchronizer flops on ack (2 or more)
// Ports:
//   clock, reset : local clock (rising edge), async active-high reset
//   in_valid     : producer has a word
//   in_data      : word to send
//   in_ready     : block can accept a word this cycle
//   tx_data      : registered word toward the receiver, stable while req=1
//   req          : registered request toward the receiver
//   ack          : asynchronous acknowledge from the receiver
//   busy         : transfer in progress
//   xfer_count   : completed transfers, wraps modulo 2^16
module handshake_tx
  import handshake_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   in_data,
  output logic               in_ready,
  output logic [WIDTH-1:0]   tx_data,
  output logic               req,
  input  logic               ack,
  output logic               busy,
  output logic [COUNT_W-1:0] xfer_count
);

  tx_state_t state;
  logic      ack_sync;
  logic      ack_s;

  flipflop_synchronizer #(
    .WIDTH        (1),
    .NUM_OF_STAGES(SYNC_STAGES)
  ) u_ack_sync (
    .clock(clock),
    .d    (ack),
    .q    (ack_sync)
  );

  // The synchronizer chain keeps running through reset, so a stale ack is
  // visible the moment reset lifts; it is only masked while reset is held.
  assign ack_s = ack_sync & ~reset;

  // Ready only in IDLE once the receiver has returned ack to zero; a stale
  // ack left over from an interrupted transfer blocks new words.
  assign in_ready = (state == IDLE) && !ack_s && !reset;
  assign busy     = (state != IDLE);

  // Handshake sequencer: raise req with the accepted word, drop it on ack,
  // and count the transfer once ack has returned low.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      req        <= 1'b0;
      tx_data    <= '0;
      xfer_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            tx_data <= in_data;
            req     <= 1'b1;
            state   <= REQ_HIGH;
          end
        end
        REQ_HIGH: begin
          if (ack_s) begin
            req   <= 1'b0;
            state <= REQ_LOW;
          end
        end
        REQ_LOW: begin
          if (!ack_s) begin
            xfer_count <= xfer_count + COUNT_W'(1);
            state      <= IDLE;
          end
        end
        default: begin
          req   <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_handshake_tx.sv
// tb_handshake_tx
// Self-checking bench for handshake_tx (WIDTH=8, SYNC_STAGES=2). The ack
// input is either looped back from req or driven directly by the bench.
// Expected values come from the handshake rules: req falls SYNC_STAGES+1
// edges after ack rises, the transfer completes SYNC_STAGES+1 edges after
// ack falls, and xfer_count advances by one per completion modulo 2^16.
module tb_handshake_tx;
  import handshake_pkg::*;

  localparam int WIDTH = 8;
  localparam int SYNC  = 2;

  logic             clock = 1'b0;
  logic             reset;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic [WIDTH-1:0] tx_data;
  logic             req;
  logic             ack;
  logic             busy;
  logic [15:0]      xfer_count;
  logic             ack_manual;
  logic             loopback;

  int checks = 0;
  int passes = 0;
  int exp_count;

  typedef struct {
    logic             valid;
    logic [WIDTH-1:0] data;
    logic             ack_in;
    logic             exp_req;
    logic [WIDTH-1:0] exp_tx;
    logic             exp_ready;
    logic             exp_busy;
    logic [15:0]      exp_cnt;
  } vec_t;

  vec_t             vecs [16];
  logic [WIDTH-1:0] words [3];
  logic [WIDTH-1:0] word;
  logic [WIDTH-1:0] held;
  logic             prev_req;
  int               nacc, last_edge, edge_n, viol, gap, d1, lat;

  assign ack = loopback ? req : ack_manual;

  handshake_tx #(
    .WIDTH      (WIDTH),
    .SYNC_STAGES(SYNC)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .tx_data   (tx_data),
    .req       (req),
    .ack       (ack),
    .busy      (busy),
    .xfer_count(xfer_count)
  );

  // Free-running local clock, 10 time units per period.
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] d, input logic a);
    in_valid   = v;
    in_data    = d;
    ack_manual = a;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  // Drive ack high, wait for req to drop, hold ack for 'hold' cycles, then
  // release it and wait for the transfer to complete.
  task automatic completeManual(input string tag, input int hold);
    int l;
    int errs;
    applyStimulus(1'($urandom_range(0, 1)), 8'($urandom), 1'b1);
    l = 0;
    do begin tick(); l++; end while (req && l < 60);
    checkOutput({tag, "_req_fall_lat"}, l, SYNC + 1);
    errs = 0;
    for (int h = 0; h < hold; h++) begin
      applyStimulus(1'($urandom_range(0, 1)), 8'($urandom), 1'b1);
      tick();
      if (req || !busy || in_ready || xfer_count !== 16'(exp_count)) errs++;
    end
    checkOutput({tag, "_hold_errs"}, errs, 0);
    applyStimulus(1'b0, 8'($urandom), 1'b0);
    l = 0;
    do begin tick(); l++; end while (busy && l < 60);
    checkOutput({tag, "_done_lat"}, l, SYNC + 1);
    exp_count = (exp_count + 1) % 65536;
    checkOutput({tag, "_count"}, xfer_count, exp_count);
  endtask

  // One transfer with ack looped back from req; minimum period applies.
  task automatic loopbackTransfer(input string tag, input logic [WIDTH-1:0] d);
    int l;
    applyStimulus(1'b1, d, 1'b0);
    tick();
    checkOutput({tag, "_tx_data"}, tx_data, d);
    applyStimulus(1'b0, 8'h00, 1'b0);
    l = 0;
    do begin tick(); l++; end while (busy && l < 60);
    checkOutput({tag, "_done_lat"}, l, 2 * SYNC + 2);
    exp_count = (exp_count + 1) % 65536;
    checkOutput({tag, "_count"}, xfer_count, exp_count);
    checkOutput({tag, "_ready"}, in_ready, 1);
  endtask

  initial begin
    reset    = 1'b1;
    loopback = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b0);

    // Cycle table for one manual transfer plus a second, starting from reset.
    //            valid data   ack  req tx     rdy  bsy  cnt
    vecs[0]  = '{1'b1, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b1, 16'd0};
    vecs[1]  = '{1'b1, 8'h3C, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b1, 16'd0};
    vecs[2]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b1, 16'd0};
    vecs[3]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b1, 16'd0};
    vecs[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b1, 16'd0};
    vecs[5]  = '{1'b1, 8'h66, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 16'd0};
    vecs[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 16'd0};
    vecs[7]  = '{1'b1, 8'h5A, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0, 16'd1};
    vecs[8]  = '{1'b1, 8'h5A, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b1, 16'd1};
    vecs[9]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b1, 16'd1};
    vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h5A, 1'b0, 1'b1, 16'd1};
    vecs[11] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h5A, 1'b0, 1'b1, 16'd1};
    vecs[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h5A, 1'b0, 1'b1, 16'd1};
    vecs[13] = '{1'b1, 8'h77, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b1, 16'd1};
    vecs[14] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b1, 16'd1};
    vecs[15] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h5A, 1'b1, 1'b0, 16'd2};

    // Reset values and in_ready during reset.
    repeat (3) begin
      tick();
      checkOutput("rst_in_ready", in_ready, 0);
    end
    checkOutput("rst_req", req, 0);
    checkOutput("rst_tx_data", tx_data, 0);
    checkOutput("rst_count", xfer_count, 0);
    checkOutput("rst_busy", busy, 0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    checkOutput("rst_release_ready", in_ready, 1);
    exp_count = 0;
    tick();

    // Table-driven manual transfers.
    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i].valid, vecs[i].data, vecs[i].ack_in);
      tick();
      checkOutput($sformatf("vec%0d_req", i), req, vecs[i].exp_req);
      checkOutput($sformatf("vec%0d_tx", i), tx_data, vecs[i].exp_tx);
      checkOutput($sformatf("vec%0d_ready", i), in_ready, vecs[i].exp_ready);
      checkOutput($sformatf("vec%0d_busy", i), busy, vecs[i].exp_busy);
      checkOutput($sformatf("vec%0d_cnt", i), xfer_count, vecs[i].exp_cnt);
    end
    exp_count = 2;

    // Loopback single transfer: req falls at edge 3, completion at edge 6.
    loopback = 1'b1;
    applyStimulus(1'b1, 8'hA5, 1'b0);
    for (int k = 0; k <= 2 * SYNC + 2; k++) begin
      tick();
      if (k == 0) begin
        checkOutput("lb_tx_data", tx_data, 8'hA5);
        applyStimulus(1'b0, 8'h00, 1'b0);
      end
      checkOutput($sformatf("lb_req_e%0d", k), req, (k < SYNC + 1) ? 1 : 0);
      checkOutput($sformatf("lb_busy_e%0d", k), busy, (k < 2 * SYNC + 2) ? 1 : 0);
      checkOutput($sformatf("lb_ready_e%0d", k), in_ready, (k >= 2 * SYNC + 2) ? 1 : 0);
      checkOutput($sformatf("lb_cnt_e%0d", k), xfer_count, (k >= 2 * SYNC + 2) ? exp_count + 1 : exp_count);
    end
    exp_count++;

    // Back-to-back with in_valid held high: accepts 2*SYNC+3 edges apart.
    words[0] = 8'h01;
    words[1] = 8'h02;
    words[2] = 8'h03;
    nacc = 0; last_edge = 0; edge_n = 0; viol = 0; prev_req = 1'b0; held = '0;
    applyStimulus(1'b1, words[0], 1'b0);
    while ((nacc < 3 || busy) && edge_n < 80) begin
      tick();
      edge_n++;
      if (req && !prev_req) begin
        checkOutput($sformatf("b2b_tx%0d", nacc), tx_data, words[nacc]);
        if (nacc > 0) checkOutput($sformatf("b2b_gap%0d", nacc), edge_n - last_edge, 2 * SYNC + 3);
        last_edge = edge_n;
        held = tx_data;
        nacc++;
        if (nacc < 3) applyStimulus(1'b1, words[nacc], 1'b0);
        else applyStimulus(1'b0, 8'h00, 1'b0);
      end else if (req && tx_data !== held) begin
        viol++;
      end
      prev_req = req;
    end
    checkOutput("b2b_accepts", nacc, 3);
    checkOutput("b2b_stable_viol", viol, 0);
    exp_count += 3;
    checkOutput("b2b_count", xfer_count, exp_count);
    loopback = 1'b0;

    // Slow receiver: ack 20 cycles after req rise, held 15 after req fall.
    applyStimulus(1'b1, 8'hC3, 1'b0);
    tick();
    checkOutput("slow_req_rise", req, 1);
    viol = 0;
    for (int c = 0; c < 19; c++) begin
      applyStimulus(1'b1, 8'($urandom), 1'b0);
      tick();
      if (!req || in_ready || tx_data !== 8'hC3) viol++;
    end
    checkOutput("slow_wait_viol", viol, 0);
    completeManual("slow", 15);
    tick();
    checkOutput("slow_no_second_req", req, 0);
    checkOutput("slow_tx_kept", tx_data, 8'hC3);

    // Reset in REQ_HIGH with ack high, released while ack is still high.
    applyStimulus(1'b1, 8'h99, 1'b0);
    tick();
    checkOutput("stale_req_before", req, 1);
    applyStimulus(1'b0, 8'h00, 1'b1);
    tick();
    #2;
    reset = 1'b1;
    #1;
    checkOutput("stale_req_async", req, 0);
    checkOutput("stale_ready_in_rst", in_ready, 0);
    checkOutput("stale_busy_in_rst", busy, 0);
    checkOutput("stale_cnt_cleared", xfer_count, 0);
    exp_count = 0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    applyStimulus(1'b1, 8'h55, 1'b1);
    reset = 1'b0;
    #1;
    checkOutput("stale_ready_release", in_ready, 0);
    viol = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (in_ready || req || busy) viol++;
    end
    checkOutput("stale_window_viol", viol, 0);
    applyStimulus(1'b1, 8'h55, 1'b0);
    tick();
    checkOutput("stale_ready_fall1", in_ready, 0);
    tick();
    checkOutput("stale_ready_fall2", in_ready, 1);
    checkOutput("stale_no_req", req, 0);
    tick();
    checkOutput("stale_accept_req", req, 1);
    checkOutput("stale_accept_tx", tx_data, 8'h55);
    completeManual("stale", 2);

    // Randomized transfers against the latency/count rules.
    for (int t = 0; t < 25; t++) begin
      gap = $urandom_range(0, 3);
      viol = 0;
      for (int g = 0; g < gap; g++) begin
        applyStimulus(1'b0, 8'($urandom), 1'b0);
        tick();
        if (!in_ready || req || busy) viol++;
      end
      word = 8'($urandom);
      applyStimulus(1'b1, word, 1'b0);
      tick();
      checkOutput("rnd_tx_data", tx_data, word);
      checkOutput("rnd_req_rise", req, 1);
      d1 = $urandom_range(0, 8);
      for (int c = 0; c < d1; c++) begin
        applyStimulus(1'($urandom_range(0, 1)), 8'($urandom), 1'b0);
        tick();
        if (!req || in_ready || tx_data !== word) viol++;
      end
      checkOutput("rnd_phase_viol", viol, 0);
      completeManual("rnd", $urandom_range(0, 6));
    end

    // Counter wrap: preload near the top, then run loopback transfers.
    loopback = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0);
    force dut.xfer_count = 16'hFFFE;
    #1;
    release dut.xfer_count;
    exp_count = 16'hFFFE;
    loopbackTransfer("wrap0", 8'h11);
    loopbackTransfer("wrap1", 8'h22);
    loopbackTransfer("wrap2", 8'h33);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
